// File: rtl/reg_wb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_wb_pkg : shared types and defaults for register writeback    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package reg_wb_pkg;

  localparam int unsigned c_register_bit = 5;
  localparam int unsigned c_data_width   = 32;
  localparam int unsigned c_fifo_depth   = 4;

  typedef struct packed {
    logic [c_register_bit-1:0] rd;
    logic [c_data_width-1:0]   data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/reg_wb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_wb_if : ALU/load-return/scoreboard/regfile-write bundle      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface reg_wb_if #(
  parameter int REGISTER_BIT = 5,
  parameter int DATA_WIDTH   = 32
) ();

  logic                    alu_valid;
  logic [REGISTER_BIT-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]   alu_data;
  logic                    alu_ready;

  logic                    mem_valid;
  logic [REGISTER_BIT-1:0] mem_rd;
  logic [DATA_WIDTH-1:0]   mem_data;
  logic                    mem_ready;

  logic                    ld_issue;
  logic [REGISTER_BIT-1:0] ld_rd;
  logic [REGISTER_BIT-1:0] rs1;
  logic [REGISTER_BIT-1:0] rs2;
  logic                    hazard;

  logic [REGISTER_BIT-1:0] AD3;
  logic [DATA_WIDTH-1:0]   WD3;
  logic                    WE3;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  ld_issue, ld_rd, rs1, rs2,
    output alu_ready, mem_ready, hazard, AD3, WD3, WE3
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output ld_issue, ld_rd, rs1, rs2,
    input  alu_ready, mem_ready, hazard, AD3, WD3, WE3
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_fifo : load-return buffer, power-of-two depth, registered     |
// | occupancy. Rev 1.0                                               |
// +------------------------------------------------------------------+
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int  FIFO_DEPTH = c_fifo_depth,
  parameter type T          = wb_req_t
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic push,
  input  wire T     push_data,
  input  wire logic pop,
  output logic      full,
  output logic      empty,
  output T          head
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  T                   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_writeback : arbitrates ALU results and buffered load returns |
// | onto one regfile write port; tracks pending loads. Rev 1.0       |
// +------------------------------------------------------------------+
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int REGISTER_BIT = c_register_bit,
  parameter int DATA_WIDTH   = c_data_width,
  parameter int FIFO_DEPTH   = c_fifo_depth
) (
  input  wire logic clk,
  input  wire logic rst_n,
  reg_wb_if.slave   wb
);

  typedef struct packed {
    logic [REGISTER_BIT-1:0] rd;
    logic [DATA_WIDTH-1:0]   data;
  } req_t;

  localparam int c_num_regs = 2 ** REGISTER_BIT;

  req_t                    w_head;
  req_t                    w_mem_req;
  req_t                    w_win;
  logic                    w_win_vld;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_push;
  logic [c_num_regs-1:0]   r_pending;
  logic [c_num_regs-1:0]   w_pending_nxt;
  logic [REGISTER_BIT-1:0] r_ad3;
  logic [DATA_WIDTH-1:0]   r_wd3;
  logic                    r_we3;

  assign w_mem_req    = '{rd: wb.mem_rd, data: wb.mem_data};
  assign w_push       = wb.mem_valid && !w_full;
  assign wb.alu_ready = !w_full;
  assign wb.mem_ready = !w_full;

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_mem_req),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  // A full buffer must drain first, otherwise the ALU has priority.
  always_comb begin
    w_pop     = 1'b0;
    w_win_vld = 1'b0;
    w_win     = '0;
    if (w_full) begin
      w_pop     = 1'b1;
      w_win_vld = 1'b1;
      w_win     = w_head;
    end else if (wb.alu_valid) begin
      w_win_vld = 1'b1;
      w_win     = '{rd: wb.alu_rd, data: wb.alu_data};
    end else if (!w_empty) begin
      w_pop     = 1'b1;
      w_win_vld = 1'b1;
      w_win     = w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ad3 <= '0;
      r_wd3 <= '0;
      r_we3 <= 1'b0;
    end else begin
      r_we3 <= w_win_vld && (w_win.rd != '0);
      if (w_win_vld) begin
        r_ad3 <= w_win.rd;
        r_wd3 <= w_win.data;
      end
    end
  end

  assign wb.AD3 = r_ad3;
  assign wb.WD3 = r_wd3;
  assign wb.WE3 = r_we3;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.rd] = 1'b0;
    if (wb.ld_issue && (wb.ld_rd != '0)) w_pending_nxt[wb.ld_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign wb.hazard = ((wb.rs1 != '0) && r_pending[wb.rs1]) ||
                     ((wb.rs2 != '0) && r_pending[wb.rs2]);

endmodule
`default_nettype wire
